// File: rtl/rggen_register_access_initiator.sv
// ---------------------------------------------------------------------------
// rggen_register_access_initiator: host request -> register block initiator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rggen_register_access_initiator #(
  parameter int                       ADDRESS_WIDTH  = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS   = '0,
  parameter int                       BYTE_SIZE      = 256,
  parameter int                       BUS_WIDTH      = 32,
  parameter int                       REGISTERS      = 1,
  parameter bit                       ERROR_STATUS   = 1'b1,
  parameter int                       TIMEOUT_CYCLES = 0
)(
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_bus_valid,
  input  logic [1:0]                     i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_bus_address,
  input  logic [BUS_WIDTH-1:0]           i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_bus_strobe,
  output logic                           o_bus_ready,
  output logic [1:0]                     o_bus_status,
  output logic [BUS_WIDTH-1:0]           o_bus_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int LSB          = $clog2(STROBE_WIDTH);
  localparam int COUNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RANGE_WIDTH  = ADDRESS_WIDTH + 1;

  localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK   = ~ADDRESS_WIDTH'((1 << LSB) - 1);
  localparam logic [RANGE_WIDTH-1:0]   RANGE_SIZE  = RANGE_WIDTH'(BYTE_SIZE);
  localparam logic [COUNT_WIDTH-1:0]   COUNT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0]   COUNT_MAX   = '1;

  localparam logic [1:0] STATUS_OKAY         = 2'b00;
  localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;
  localparam logic [1:0] UNMATCHED_STATUS    = ERROR_STATUS ? STATUS_DECODE_ERROR : STATUS_OKAY;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  state_e                   r_state,      w_state_next;
  logic                     r_valid,      w_valid_next;
  logic [1:0]               r_access,     w_access_next;
  logic [ADDRESS_WIDTH-1:0] r_address,    w_address_next;
  logic [BUS_WIDTH-1:0]     r_write_data, w_write_data_next;
  logic [STROBE_WIDTH-1:0]  r_strobe,     w_strobe_next;
  logic [COUNT_WIDTH-1:0]   r_count,      w_count_next;
  logic                     r_bus_ready,  w_bus_ready_next;
  logic [1:0]               r_bus_status, w_bus_status_next;
  logic [BUS_WIDTH-1:0]     r_bus_read_data, w_bus_read_data_next;

  logic [RANGE_WIDTH-1:0]   w_offset;
  logic                     w_in_range;
  logic                     w_active;
  logic                     w_ready;
  logic [1:0]               w_status;
  logic [BUS_WIDTH-1:0]     w_read_data;
  logic [COUNT_WIDTH-1:0]   w_count_inc;

  // Addresses below the base wrap into the extra top bit, so one compare covers both bounds.
  assign w_offset   = {1'b0, i_bus_address} - {1'b0, BASE_ADDRESS};
  assign w_in_range = (w_offset < RANGE_SIZE);

  always_comb begin
    w_active    = |i_register_active;
    w_ready     = 1'b0;
    w_status    = '0;
    w_read_data = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (i_register_active[i]) begin
        w_ready     = w_ready | i_register_ready[i];
        w_status    = w_status | i_register_status[2*i+:2];
        w_read_data = w_read_data | i_register_read_data[BUS_WIDTH*i+:BUS_WIDTH];
      end
    end
  end

  assign w_count_inc = (r_count == COUNT_MAX) ? r_count : r_count + 1'b1;

  always_comb begin
    w_state_next         = r_state;
    w_valid_next         = 1'b0;
    w_access_next        = r_access;
    w_address_next       = r_address;
    w_write_data_next    = r_write_data;
    w_strobe_next        = r_strobe;
    w_count_next         = r_count;
    w_bus_ready_next     = 1'b0;
    w_bus_status_next    = '0;
    w_bus_read_data_next = '0;
    case (r_state)
      IDLE: begin
        w_count_next = '0;
        if (i_bus_valid) begin
          w_access_next     = i_bus_access;
          w_address_next    = i_bus_address & WORD_MASK;
          w_write_data_next = i_bus_write_data;
          w_strobe_next     = i_bus_strobe;
          if (w_in_range) begin
            w_state_next = REQUEST;
            w_valid_next = 1'b1;
          end else begin
            w_state_next      = RESPONSE;
            w_bus_ready_next  = 1'b1;
            w_bus_status_next = STATUS_DECODE_ERROR;
          end
        end
      end
      REQUEST: begin
        w_valid_next = 1'b1;
        if (!w_active) begin
          w_state_next      = RESPONSE;
          w_valid_next      = 1'b0;
          w_count_next      = '0;
          w_bus_ready_next  = 1'b1;
          w_bus_status_next = UNMATCHED_STATUS;
        end else if (w_ready) begin
          w_state_next         = RESPONSE;
          w_valid_next         = 1'b0;
          w_count_next         = '0;
          w_bus_ready_next     = 1'b1;
          w_bus_status_next    = w_status;
          w_bus_read_data_next = r_access[0] ? '0 : w_read_data;
        end else begin
          w_count_next = w_count_inc;
          if ((TIMEOUT_CYCLES != 0) && (w_count_inc == COUNT_LIMIT)) begin
            w_state_next      = RESPONSE;
            w_valid_next      = 1'b0;
            w_count_next      = '0;
            w_bus_ready_next  = 1'b1;
            w_bus_status_next = STATUS_SLAVE_ERROR;
          end
        end
      end
      RESPONSE: begin
        w_state_next = IDLE;
        w_count_next = '0;
      end
      default: begin
        w_state_next = IDLE;
        w_count_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= IDLE;
      r_valid         <= 1'b0;
      r_access        <= '0;
      r_address       <= '0;
      r_write_data    <= '0;
      r_strobe        <= '0;
      r_count         <= '0;
      r_bus_ready     <= 1'b0;
      r_bus_status    <= '0;
      r_bus_read_data <= '0;
    end else begin
      r_state         <= w_state_next;
      r_valid         <= w_valid_next;
      r_access        <= w_access_next;
      r_address       <= w_address_next;
      r_write_data    <= w_write_data_next;
      r_strobe        <= w_strobe_next;
      r_count         <= w_count_next;
      r_bus_ready     <= w_bus_ready_next;
      r_bus_status    <= w_bus_status_next;
      r_bus_read_data <= w_bus_read_data_next;
    end
  end

  assign o_bus_ready           = r_bus_ready;
  assign o_bus_status          = r_bus_status;
  assign o_bus_read_data       = r_bus_read_data;
  assign o_register_valid      = r_valid;
  assign o_register_access     = r_access;
  assign o_register_address    = r_address;
  assign o_register_write_data = r_write_data;
  assign o_register_strobe     = r_strobe;

endmodule

`default_nettype wire

// File: tb/tb_rggen_register_access_initiator.sv
// ---------------------------------------------------------------------------
// tb_rggen_register_access_initiator: randomized and directed checks against a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rggen_register_access_initiator;

  localparam int AW     = 8;
  localparam int BW     = 32;
  localparam int NR     = 2;
  localparam int BS     = 16;
  localparam int A_BASE = 0;
  localparam int TO     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: two registers, decode errors on, timeout 4
  logic            bus_valid = 1'b0;
  logic [1:0]      bus_access = '0;
  logic [AW-1:0]   bus_address = '0;
  logic [BW-1:0]   bus_wdata = '0;
  logic [BW/8-1:0] bus_strobe = '0;
  logic            bus_ready;
  logic [1:0]      bus_status;
  logic [BW-1:0]   bus_rdata;
  logic            reg_valid;
  logic [1:0]      reg_access;
  logic [AW-1:0]   reg_address;
  logic [BW-1:0]   reg_wdata;
  logic [BW/8-1:0] reg_strobe;
  logic [NR-1:0]   reg_active;
  logic [NR-1:0]   reg_ready;
  logic [2*NR-1:0] reg_status;
  logic [BW*NR-1:0] reg_rdata;

  // DUT B: one register at base 0x40, unmatched -> OKAY, no timeout
  logic            b_valid = 1'b0;
  logic [1:0]      b_access = '0;
  logic [AW-1:0]   b_address = '0;
  logic [BW-1:0]   b_wdata = '0;
  logic [BW/8-1:0] b_strobe = '0;
  logic            b_ready;
  logic [1:0]      b_status;
  logic [BW-1:0]   b_rdata;
  logic            b_reg_valid;
  logic [1:0]      b_reg_access;
  logic [AW-1:0]   b_reg_address;
  logic [BW-1:0]   b_reg_wdata;
  logic [BW/8-1:0] b_reg_strobe;
  logic            b_active = 1'b0;
  logic            b_reg_ready = 1'b1;
  logic [1:0]      b_reg_status = 2'b01;
  logic [BW-1:0]   b_reg_rdata = 32'hA5A5_5A5A;

  rggen_register_access_initiator #(
    .ADDRESS_WIDTH(AW), .BASE_ADDRESS(8'h00), .BYTE_SIZE(BS), .BUS_WIDTH(BW),
    .REGISTERS(NR), .ERROR_STATUS(1'b1), .TIMEOUT_CYCLES(TO)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_bus_valid(bus_valid), .i_bus_access(bus_access), .i_bus_address(bus_address),
    .i_bus_write_data(bus_wdata), .i_bus_strobe(bus_strobe),
    .o_bus_ready(bus_ready), .o_bus_status(bus_status), .o_bus_read_data(bus_rdata),
    .o_register_valid(reg_valid), .o_register_access(reg_access),
    .o_register_address(reg_address), .o_register_write_data(reg_wdata),
    .o_register_strobe(reg_strobe),
    .i_register_active(reg_active), .i_register_ready(reg_ready),
    .i_register_status(reg_status), .i_register_read_data(reg_rdata)
  );

  rggen_register_access_initiator #(
    .ADDRESS_WIDTH(AW), .BASE_ADDRESS(8'h40), .BYTE_SIZE(32), .BUS_WIDTH(BW),
    .REGISTERS(1), .ERROR_STATUS(1'b0), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_bus_valid(b_valid), .i_bus_access(b_access), .i_bus_address(b_address),
    .i_bus_write_data(b_wdata), .i_bus_strobe(b_strobe),
    .o_bus_ready(b_ready), .o_bus_status(b_status), .o_bus_read_data(b_rdata),
    .o_register_valid(b_reg_valid), .o_register_access(b_reg_access),
    .o_register_address(b_reg_address), .o_register_write_data(b_reg_wdata),
    .o_register_strobe(b_reg_strobe),
    .i_register_active(b_active), .i_register_ready(b_reg_ready),
    .i_register_status(b_reg_status), .i_register_read_data(b_reg_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-side responder for DUT A: the active register answers after plan_delay
  // cycles of valid; the other register carries random noise that must be ignored.
  bit          plan_has = 1'b0;
  bit          plan_idx = 1'b0;
  int          plan_delay = 0;
  logic [1:0]  plan_status = '0;
  logic [31:0] plan_data = '0;
  logic        noise_ready = 1'b0;
  logic [1:0]  noise_status = '0;
  logic [31:0] noise_data = '0;
  int          wcnt = 0;

  always @(posedge clk) wcnt <= reg_valid ? wcnt + 1 : 0;

  always_comb begin
    reg_active = '0;
    reg_ready  = {NR{noise_ready}};
    reg_status = {NR{noise_status}};
    reg_rdata  = {NR{noise_data}};
    if (plan_has) begin
      if (plan_idx) begin
        reg_active[1]     = 1'b1;
        reg_ready[1]      = (wcnt >= plan_delay);
        reg_status[3:2]   = plan_status;
        reg_rdata[63:32]  = plan_data;
      end else begin
        reg_active[0]     = 1'b1;
        reg_ready[0]      = (wcnt >= plan_delay);
        reg_status[1:0]   = plan_status;
        reg_rdata[31:0]   = plan_data;
      end
    end
  end

  // Transaction-level expectation: latency in cycles from the accept cycle, status, data.
  function automatic void model(input logic [1:0] acc, input logic [7:0] addr, input bit has,
                                input int delay, input logic [1:0] st, input logic [31:0] d,
                                output int lat, output logic [1:0] est, output logic [31:0] ed);
    bit in_range;
    in_range = (int'(addr) >= A_BASE) && (int'(addr) < A_BASE + BS);
    if (!in_range) begin
      lat = 1; est = 2'b11; ed = '0;
    end else if (!has) begin
      lat = 2; est = 2'b11; ed = '0;
    end else if (delay >= TO) begin
      lat = TO + 1; est = 2'b10; ed = '0;
    end else begin
      lat = delay + 2; est = st; ed = acc[0] ? 32'h0 : d;
    end
  endfunction

  task automatic run_a(input logic [1:0] acc, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input bit has, input bit idx, input int delay,
                       input logic [1:0] st, input logic [31:0] d, input bit drop, input bit hold);
    int          exp_lat, lat;
    logic [1:0]  exp_st;
    logic [31:0] exp_d;
    bit          in_range, seen_valid;
    model(acc, addr, has, delay, st, d, exp_lat, exp_st, exp_d);
    in_range     = (int'(addr) < A_BASE + BS);
    plan_has     = has;
    plan_idx     = idx;
    plan_delay   = delay;
    plan_status  = st;
    plan_data    = d;
    noise_ready  = 1'($urandom);
    noise_status = 2'($urandom);
    noise_data   = $urandom;
    bus_access   = acc;
    bus_address  = addr;
    bus_wdata    = wd;
    bus_strobe   = strb;
    bus_valid    = 1'b1;
    lat = 0;
    seen_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1 && drop) bus_valid = 1'b0;
      if (n == 1 && in_range) begin
        check("reg_valid", reg_valid, 1);
        check("reg_access", reg_access, acc);
        check("reg_address", reg_address, addr & 8'hFC);
        check("reg_wdata", reg_wdata, wd);
        check("reg_strobe", reg_strobe, strb);
      end
      if (reg_valid) seen_valid = 1'b1;
      if (bus_ready) begin
        lat = n;
        break;
      end
    end
    check("latency", lat, exp_lat);
    check("status", bus_status, exp_st);
    check("rdata", bus_rdata, exp_d);
    if (!in_range) check("oor_no_reg_valid", seen_valid, 0);
    if (!hold) bus_valid = 1'b0;
    @(posedge clk); #1;
    check("post_ready", bus_ready, 0);
    check("post_status", bus_status, 0);
    check("post_rdata", bus_rdata, 0);
    check("post_reg_valid", reg_valid, 0);
  endtask

  task automatic run_b(input logic [7:0] addr, input bit act, input bit wr, input int elat,
                       input logic [1:0] est, input logic [31:0] ed);
    int lat;
    b_active  = act;
    b_access  = {1'b0, wr};
    b_address = addr;
    b_wdata   = 32'h1111_2222;
    b_strobe  = 4'hF;
    b_valid   = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (b_ready) begin
        lat = n;
        break;
      end
    end
    check("b_latency", lat, elat);
    check("b_status", b_status, est);
    check("b_rdata", b_rdata, ed);
    b_valid = 1'b0;
    @(posedge clk); #1;
    check("b_post_ready", b_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_ready", bus_ready, 0);
    check("rst_bus_status", bus_status, 0);
    check("rst_bus_rdata", bus_rdata, 0);
    check("rst_reg_valid", reg_valid, 0);
    check("rst_reg_address", reg_address, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_a(2'b00, 8'h04, 32'h0, 4'h0, 1, 1, 0, 2'b00, 32'hCAFE_F00D, 0, 0);
    run_a(2'b01, 8'h02, 32'h1234_5678, 4'h3, 1, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, 0);
    run_a(2'b00, 8'h08, 32'h0, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0, 0);
    run_a(2'b00, 8'h20, 32'h0, 4'hF, 1, 0, 0, 2'b00, 32'h5555_AAAA, 0, 0);
    run_a(2'b00, 8'h0C, 32'h0, 4'hF, 1, 0, 10, 2'b00, 32'h7777_1111, 0, 0);
    run_a(2'b00, 8'h0C, 32'h0, 4'hF, 1, 0, 2, 2'b00, 32'h0BAD_CAFE, 0, 0);
    run_a(2'b10, 8'h0F, 32'h0, 4'hF, 1, 1, 3, 2'b01, 32'h1357_9BDF, 1, 0);
    run_a(2'b00, 8'h10, 32'h0, 4'hF, 1, 1, 0, 2'b00, 32'h2468_ACE0, 0, 1);

    for (int t = 0; t < 60; t++) begin
      bit d, h;
      d = ($urandom_range(0, 4) == 0);
      h = !d && ($urandom_range(0, 3) == 0);
      run_a(2'($urandom), 8'($urandom_range(0, 31)), $urandom, 4'($urandom),
            ($urandom_range(0, 3) != 0), 1'($urandom), $urandom_range(0, 6),
            2'($urandom), $urandom, d, h);
    end

    // Reset while a request is outstanding
    plan_has    = 1'b1;
    plan_idx    = 1'b0;
    plan_delay  = 30;
    bus_access  = 2'b01;
    bus_address = 8'h0C;
    bus_wdata   = 32'hFFFF_0000;
    bus_strobe  = 4'hF;
    bus_valid   = 1'b1;
    @(posedge clk); #1;
    check("abort_pre_valid", reg_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_reg_valid", reg_valid, 0);
    check("abort_reg_address", reg_address, 0);
    check("abort_reg_wdata", reg_wdata, 0);
    check("abort_reg_strobe", reg_strobe, 0);
    check("abort_reg_access", reg_access, 0);
    check("abort_bus_ready", bus_ready, 0);
    bus_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_response", bus_ready, 0);
    run_a(2'b00, 8'h04, 32'h0, 4'hF, 1, 1, 1, 2'b00, 32'h600D_600D, 0, 0);

    run_b(8'h3C, 1, 0, 1, 2'b11, 32'h0);
    run_b(8'h40, 0, 0, 2, 2'b00, 32'h0);
    run_b(8'h5F, 1, 0, 2, 2'b01, 32'hA5A5_5A5A);
    run_b(8'h60, 1, 0, 1, 2'b11, 32'h0);
    run_b(8'h44, 1, 1, 2, 2'b01, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
